// File: rtl/conv1d_ctrl.sv
// conv1d_ctrl: sequencer for a 1-D convolution datapath.
// It fills a NUM_TAPS-deep delay line, then steps the MAC through every tap
// and holds each finished output until downstream accepts it. After the first
// window, each further output needs only one new sample.
// Optional feature: define CONV1D_CTRL_ABORT_EN to add an `abort` input. It
// drops any active run back to IDLE without a done pulse.
module conv1d_ctrl #(
  parameter int NUM_TAPS = 4,
  parameter int LEN_W    = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
`ifdef CONV1D_CTRL_ABORT_EN
  input  logic                        abort,
`endif
  input  logic [LEN_W-1:0]            len,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        shift_en,
  output logic [$clog2(NUM_TAPS)-1:0] tap_sel,
  output logic                        mac_clr,
  output logic                        mac_en,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        done
);

  localparam int TAP_W = $clog2(NUM_TAPS);
  localparam logic [TAP_W-1:0] TAP_MAX = TAP_W'(NUM_TAPS - 1);
  localparam logic [LEN_W:0]   TAPS_L  = (LEN_W+1)'(NUM_TAPS);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_MAC  = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       state;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_q;
  logic [TAP_W-1:0] tap;
  logic [LEN_W:0]   cnt_inc;
  logic             kill;

  // The counter never passes len, and len is at most 2^LEN_W-1. The extra bit
  // only keeps the NUM_TAPS compare exact.
  assign cnt_inc = {1'b0, cnt} + (LEN_W+1)'(1);

`ifdef CONV1D_CTRL_ABORT_EN
  assign kill = abort && (state != S_IDLE);
`else
  assign kill = 1'b0;
`endif

  // Decode outputs from state. Holding reset forces every output quiet at once.
  always_comb begin
    in_ready  = 1'b0;
    mac_en    = 1'b0;
    mac_clr   = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    tap_sel   = '0;
    if (reset) begin
      case (state)
        S_LOAD: in_ready = 1'b1;
        S_MAC: begin
          mac_en  = 1'b1;
          mac_clr = (tap == '0);
          tap_sel = tap;
        end
        S_OUT:  out_valid = 1'b1;
        S_DONE: done = !kill;
        default: ;
      endcase
    end
    shift_en = in_valid && in_ready;
    busy     = reset && (state != S_IDLE);
  end

  // FSM, sample counter, captured length and tap index.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      len_q <= '0;
      tap   <= '0;
    end else if (kill) begin
      state <= S_IDLE;
      cnt   <= '0;
      len_q <= '0;
      tap   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q <= len;
            cnt   <= '0;
            tap   <= '0;
            state <= ({1'b0, len} >= TAPS_L) ? S_LOAD : S_DONE;
          end
        end
        S_LOAD: begin
          // First window: wait for NUM_TAPS samples. Later windows: one sample.
          if (shift_en) begin
            cnt <= cnt_inc[LEN_W-1:0];
            tap <= '0;
            if (cnt_inc >= TAPS_L) state <= S_MAC;
          end
        end
        S_MAC: begin
          if (tap == TAP_MAX) begin
            tap   <= '0;
            state <= S_OUT;
          end else begin
            tap <= tap + TAP_W'(1);
          end
        end
        S_OUT: begin
          if (out_ready) state <= (cnt == len_q) ? S_DONE : S_LOAD;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv1d_ctrl.sv
// Directed bench for conv1d_ctrl. It uses NUM_TAPS=4 and LEN_W=4, so a
// full-scale len (15) run finishes quickly.
module tb_conv1d_ctrl;
  localparam int NT = 4;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
`ifdef CONV1D_CTRL_ABORT_EN
  logic          abort = 1'b0;
`endif
  logic          in_ready, shift_en, mac_clr, mac_en, out_valid, busy, done;
  logic [1:0]    tap_sel;

  conv1d_ctrl #(.NUM_TAPS(NT), .LEN_W(LW)) dut (
    .clk(clk), .reset(reset), .start(start),
`ifdef CONV1D_CTRL_ABORT_EN
    .abort(abort),
`endif
    .len(len), .in_valid(in_valid), .in_ready(in_ready), .shift_en(shift_en),
    .tap_sel(tap_sel), .mac_clr(mac_clr), .mac_en(mac_en), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_shift = 0, n_mac = 0, n_out = 0, n_done = 0, n_proto = 0;
  int exp_tap = 0;

  // Event counters plus protocol rules that must hold on every cycle.
  always @(negedge clk) begin
    if (shift_en) n_shift++;
    if (mac_en) n_mac++;
    if (out_valid && out_ready) n_out++;
    if (done) n_done++;
    if (shift_en !== (in_valid && in_ready)) n_proto++;
    if (shift_en && (mac_en || mac_clr)) n_proto++;
    if (mac_clr && !mac_en) n_proto++;
    if (out_valid && in_ready) n_proto++;
    if (mac_en) begin
      if (int'(tap_sel) != exp_tap || mac_clr !== (exp_tap == 0)) n_proto++;
      exp_tap = (exp_tap == NT - 1) ? 0 : exp_tap + 1;
    end else begin
      exp_tap = 0;
    end
  end

  task automatic go(input logic [LW-1:0] l);
    start = 1'b1;
    len = l;
    @(posedge clk); #1;
    start = 1'b0;
    len = ~l;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b1; len = 4'd6; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, shift_en, mac_en, mac_clr, out_valid, busy, done, tap_sel} !== 9'd0) begin
      errors++; $display("FAIL reset_hold outputs=%b want 0",
        {in_ready, shift_en, mac_en, mac_clr, out_valid, busy, done, tap_sel});
    end
    repeat (2) @(posedge clk);
    #1; reset = 1'b1; start = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, shift_en, mac_en, mac_clr, out_valid, busy, done, tap_sel} !== 9'd0) begin
      errors++; $display("FAIL reset_release outputs=%b want 0",
        {in_ready, shift_en, mac_en, mac_clr, out_valid, busy, done, tap_sel});
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy=%b want 0", busy); end
  endtask

  task automatic test_basic;
    int s0, m0, o0, d0, p0;
    bit ok, seen;
    in_valid = 1'b1; out_ready = 1'b1;
    s0 = n_shift; m0 = n_mac; o0 = n_out; d0 = n_done; p0 = n_proto;
    go(4'd6);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL basic_load busy=%b in_ready=%b want 1 1", busy, in_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mac_en === 1'b1) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || n_shift - s0 != 4 || tap_sel !== 2'd0 || mac_clr !== 1'b1) begin
      errors++; $display("FAIL basic_first_mac seen=%0d shifts=%0d tap=%0d clr=%b want 1 4 0 1",
        seen, n_shift - s0, tap_sel, mac_clr);
    end
    for (int k = 1; k < NT; k++) begin
      @(negedge clk);
      checks++;
      if (mac_en !== 1'b1 || int'(tap_sel) != k || mac_clr !== 1'b0) begin
        errors++; $display("FAIL basic_tap en=%b tap=%0d clr=%b want 1 %0d 0", mac_en, tap_sel, mac_clr, k);
      end
    end
    wait_done(200, ok);
    checks++;
    if (!ok || n_out - o0 != 3 || n_shift - s0 != 6 || n_mac - m0 != 12 || n_done - d0 != 1) begin
      errors++; $display("FAIL basic_counts ok=%0d out=%0d shift=%0d mac=%0d done=%0d want 1 3 6 12 1",
        ok, n_out - o0, n_shift - s0, n_mac - m0, n_done - d0);
    end
    checks++;
    if (n_proto != p0) begin errors++; $display("FAIL basic_protocol violations=%0d want 0", n_proto - p0); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL basic_idle busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_short;
    int s0, o0;
    in_valid = 1'b1; out_ready = 1'b1;
    s0 = n_shift; o0 = n_out;
    go(4'd3);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL short_done done=%b busy=%b in_ready=%b want 1 1 0", done, busy, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || n_shift != s0 || n_out != o0) begin
      errors++; $display("FAIL short_after busy=%b done=%b shift=%0d out=%0d want 0 0 0 0",
        busy, done, n_shift - s0, n_out - o0);
    end
  endtask

  task automatic test_backpressure;
    int o0, d0;
    bit ok, seen;
    in_valid = 1'b1; out_ready = 1'b0;
    o0 = n_out; d0 = n_done;
    go(4'd6);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL bp_reach_out out_valid=%b want 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold cycle=%0d out_valid=%b in_ready=%b want 1 0", i, out_valid, in_ready);
      end
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_done(200, ok);
    checks++;
    if (!ok || n_out - o0 != 3 || n_done - d0 != 1) begin
      errors++; $display("FAIL bp_resume ok=%0d out=%0d done=%0d want 1 3 1", ok, n_out - o0, n_done - d0);
    end
  endtask

  task automatic test_toggle;
    int s0, o0, p0;
    bit ok;
    in_valid = 1'b0; out_ready = 1'b1;
    s0 = n_shift; o0 = n_out; p0 = n_proto;
    go(4'd6);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      in_valid = ~in_valid;
      @(negedge clk);
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b1;
    checks++;
    if (!ok || n_shift - s0 != 6 || n_out - o0 != 3 || n_proto != p0) begin
      errors++; $display("FAIL toggle ok=%0d shift=%0d out=%0d viol=%0d want 1 6 3 0",
        ok, n_shift - s0, n_out - o0, n_proto - p0);
    end
  endtask

  task automatic test_reset_mid;
    int s0, o0, d0;
    bit ok, seen;
    in_valid = 1'b1; out_ready = 1'b1;
    go(4'd6);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mac_en === 1'b1 && tap_sel === 2'd2) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rst_mid_reach tap=%0d want 2", tap_sel); end
    d0 = n_done;
    #1; reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    checks++;
    if ({in_ready, shift_en, mac_en, mac_clr, out_valid, busy, done, tap_sel} !== 9'd0) begin
      errors++; $display("FAIL rst_mid_idle outputs=%b want 0",
        {in_ready, shift_en, mac_en, mac_clr, out_valid, busy, done, tap_sel});
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (n_done != d0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_nodone done=%0d busy=%b want 0 0", n_done - d0, busy);
    end
    s0 = n_shift; o0 = n_out; d0 = n_done;
    go(4'd4);
    wait_done(100, ok);
    checks++;
    if (!ok || n_out - o0 != 1 || n_shift - s0 != 4 || n_done - d0 != 1) begin
      errors++; $display("FAIL rst_mid_fresh ok=%0d out=%0d shift=%0d done=%0d want 1 1 4 1",
        ok, n_out - o0, n_shift - s0, n_done - d0);
    end
  endtask

  task automatic test_max_len;
    int s0, m0, o0, d0;
    bit ok;
    in_valid = 1'b1; out_ready = 1'b1;
    s0 = n_shift; m0 = n_mac; o0 = n_out; d0 = n_done;
    go(4'd15);
    wait_done(300, ok);
    checks++;
    if (!ok || n_out - o0 != 12 || n_shift - s0 != 15 || n_mac - m0 != 48 || n_done - d0 != 1) begin
      errors++; $display("FAIL max_len ok=%0d out=%0d shift=%0d mac=%0d done=%0d want 1 12 15 48 1",
        ok, n_out - o0, n_shift - s0, n_mac - m0, n_done - d0);
    end
  endtask

  task automatic test_start_ignored;
    int o0, d0;
    bit ok;
    in_valid = 1'b1; out_ready = 1'b1;
    o0 = n_out; d0 = n_done;
    go(4'd6);
    repeat (3) @(posedge clk);
    #1; start = 1'b1; len = 4'd4;
    repeat (2) @(posedge clk);
    #1; start = 1'b0;
    wait_done(200, ok);
    checks++;
    if (!ok || n_out - o0 != 3 || n_done - d0 != 1) begin
      errors++; $display("FAIL start_ignored ok=%0d out=%0d done=%0d want 1 3 1", ok, n_out - o0, n_done - d0);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_ignored_idle busy=%b want 0", busy); end
  endtask

`ifdef CONV1D_CTRL_ABORT_EN
  task automatic test_abort;
    int o0, d0;
    bit ok, seen;
    in_valid = 1'b1; out_ready = 1'b0;
    go(4'd6);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin seen = 1'b1; break; end
    end
    d0 = n_done;
    #1; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (!seen || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_out seen=%0d out_valid=%b busy=%b want 1 0 0", seen, out_valid, busy);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (n_done != d0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_nodone done=%0d busy=%b want 0 0", n_done - d0, busy);
    end
    o0 = n_out;
    out_ready = 1'b1;
    abort = 1'b1; start = 1'b1; len = 4'd4;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_idle_start busy=%b want 1", busy); end
    wait_done(100, ok);
    checks++;
    if (!ok || n_out - o0 != 1) begin
      errors++; $display("FAIL abort_rerun ok=%0d out=%0d want 1 1", ok, n_out - o0);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_short;
    test_backpressure;
    test_toggle;
    test_reset_mid;
    test_max_len;
    test_start_ignored;
`ifdef CONV1D_CTRL_ABORT_EN
    test_abort;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv1d_ctrl.md
CONV1D_CTRL -- requirements
Module: conv1d_ctrl

Interface
REQ-001 SHALL have parameter NUM_TAPS, default 4, filter taps / delay-line depth (range 2..16).
REQ-002 SHALL have parameter LEN_W, default 16, width of the sample-count input.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset sampled on the rising clk edge.
REQ-005 SHALL have port start, input, 1, begin a run; honoured only in IDLE.
REQ-006 SHALL have port len, input, LEN_W, number of input samples in the run; captured on the start cycle.
REQ-007 SHALL have port in_valid, input, 1, upstream sample available.
REQ-008 SHALL have port in_ready, output, 1, controller accepts a sample; transfer occurs when in_valid and in_ready are both 1.
REQ-009 SHALL have port shift_en, output, 1, delay-line register enable, equal to the in_valid and in_ready transfer.
REQ-010 SHALL have port tap_sel, output, $clog2(NUM_TAPS), tap/coefficient index for the MAC.
REQ-011 SHALL have port mac_clr, output, 1, MAC loads the product instead of accumulating it.
REQ-012 SHALL have port mac_en, output, 1, MAC update enable.
REQ-013 SHALL have port out_valid, output, 1, accumulator holds a finished output.
REQ-014 SHALL have port out_ready, input, 1, downstream accepts an output.
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-016 SHALL have port done, output, 1, one-cycle pulse at run end.

Function
REQ-017 SHALL implement states IDLE, LOAD, MAC, OUT, DONE.
REQ-018 IDLE: when start is 1, SHALL capture len, clear the sample counter, and enter LOAD if len >= NUM_TAPS, otherwise enter DONE (zero outputs, no samples consumed).
REQ-019 LOAD: in_ready SHALL be 1; each transfer SHALL increment the sample counter and pulse shift_en for exactly one cycle.
REQ-020 LOAD SHALL move to MAC on the cycle after the transfer that makes the counter reach NUM_TAPS on the first window, or after exactly one transfer on later windows.
REQ-021 MAC SHALL last exactly NUM_TAPS cycles, with mac_en=1 and tap_sel=0..NUM_TAPS-1 ascending; mac_clr SHALL be 1 only at tap_sel=0; in_ready SHALL be 0.
REQ-022 OUT: out_valid SHALL hold at 1 until out_ready is 1; out_valid SHALL not drop without a handshake.
REQ-023 On the OUT handshake, the controller SHALL go to DONE if the sample counter equals len, otherwise to LOAD.
REQ-024 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-025 Outputs per run SHALL be len-NUM_TAPS+1; input samples consumed per run SHALL be exactly len.
REQ-026 start outside IDLE SHALL be ignored; len changes after capture SHALL be ignored.
REQ-027 Counter width SHALL be LEN_W with no wrap; len = 2^LEN_W-1 SHALL complete correctly.
REQ-028 shift_en, mac_en, and mac_clr SHALL never be 1 in the same cycle.

Reset
REQ-029 With reset=0 at a clock edge, the controller SHALL enter IDLE and clear the counters and captured len.
REQ-030 During and after reset: in_ready, shift_en, mac_en, mac_clr, out_valid, busy, done SHALL be 0, and tap_sel SHALL be 0.
REQ-031 Reset mid-run (any state) SHALL abandon the run with no done pulse; the next start SHALL begin a fresh run.

Configuration
REQ-032 Macro CONV1D_CTRL_ABORT_EN: when defined, SHALL add input abort (1 bit); abort=1 in any non-IDLE state SHALL force IDLE on the next edge, all outputs as in reset, and no done pulse; abort in IDLE SHALL have no effect; reset SHALL have priority over abort.
REQ-033 When CONV1D_CTRL_ABORT_EN is undefined, the abort port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-034 NUM_TAPS=4, len=6, in_valid and out_ready held at 1 -> 4 shift pulses, then 4 mac_en cycles (tap_sel 0,1,2,3, mac_clr at 0), 3 outputs total, 6 shift pulses, one done pulse.
REQ-035 len=3 with NUM_TAPS=4 -> DONE on the cycle after start, in_ready never 1, zero outputs.
REQ-036 out_ready held at 0 for 5 cycles in OUT -> out_valid stays at 1 and in_ready stays at 0; the run resumes after out_ready=1.
REQ-037 in_valid toggling 1/0 in LOAD -> shift_en only on the transfer cycles; output count unchanged (3 for len=6).
REQ-038 reset=0 during MAC at tap_sel=2 -> next cycle IDLE with all outputs 0 and no done pulse; a new start with len=4 gives one output.
REQ-039 With CONV1D_CTRL_ABORT_EN defined: abort=1 in OUT -> IDLE next cycle, out_valid=0, no done pulse; start asserted while busy -> ignored.
